clk_rst_ctrl: RTL
=================

Name: clk_rst_ctrl

Overview:
Parametrised clock-phase and reset controller sitting between the board pins and the core/memory subsystem in top.
- Debounces NUM_BTN push-buttons; channel 0 is the system reset button.
- Sequences core reset release with a programmable hold time.
- Generates one-hot phase strobes (clock enables) so a multi-cycle core with synchronous BSRAM runs from a single clock instead of derived clocks.

Parameters:
NUM_BTN, 1, number of button channels (>=1); channel 0 drives core reset
DEB_LEN, 16, cycles a synchronised input must be stable before the debounced level changes (>=2)
NUM_PHASES, 3, phases per instruction in multi-phase mode (>=2)
RST_HOLD, 8, cycles core_rst_o stays high after reset sources release (>=1)
BTN_ACTIVE_LOW, 1, 1 = pin low means pressed

Ports:
clk  in  1  single system clock; all logic on posedge
rst  in  1  synchronous, active-high reset (e.g. PLL not locked)
btn_i  in  NUM_BTN  raw asynchronous button pins
mode_i  in  1  0 = single-phase (all strobes every cycle), 1 = multi-phase rotation
btn_o  out  NUM_BTN  debounced level, 1 = pressed
btn_rise_o  out  NUM_BTN  one-cycle pulse on press
btn_fall_o  out  NUM_BTN  one-cycle pulse on release
core_rst_o  out  1  synchronous active-high reset to core and memories
phase_o  out  NUM_PHASES  phase strobes; bit0 = core, bit1 = imem, bit2 = dmem by convention
phase_idx_o  out  $clog2(NUM_PHASES)  current phase index

Behaviour:
- Reset values while rst=1: btn_o=0, btn_rise_o=0, btn_fall_o=0, core_rst_o=1, phase_o=0, phase_idx_o=0.
- Reset state: debounce counters 0; synchroniser flops at the "released" level; FSM in ASSERT.
- Input conditioning: each btn_i passes through a 2-flop synchroniser, then is inverted if BTN_ACTIVE_LOW.
- Debounce, per channel, with counter width $clog2(DEB_LEN):
  - Synchronised level == btn_o: counter clears.
  - Otherwise the counter increments. When it equals DEB_LEN-1 and the levels still differ, btn_o toggles and the counter clears.
  - Any mismatch gap restarts the count (glitch rejection).
- Debounce latency: a pin edge held stable from cycle t changes btn_o at the clock edge ending cycle t+DEB_LEN+2.
- Edge pulses: btn_rise_o/btn_fall_o are registered and high for exactly the cycle in which btn_o has its new value.
- Reset FSM states:
  - ASSERT: core_rst_o=1, phase counter held at 0. Go to HOLD when rst=0 and btn_o[0]=0.
  - HOLD: core_rst_o=1, hold counter counts 0..RST_HOLD-1. Go to RUN after RST_HOLD cycles. Return to ASSERT if btn_o[0]=1.
  - RUN: core_rst_o=0. Go to ASSERT on btn_o[0]=1 (rst is handled by the global reset).
- mode_i sampling: mode_i is latched into mode_q every cycle in ASSERT/HOLD only. It is frozen in RUN, so a mid-run change has no effect until the next reset.
- Phase generation: a counter runs only in RUN and wraps at NUM_PHASES-1 → 0. The first RUN cycle is phase 0.
  - mode_q=1: phase_o = one-hot(phase_idx_o).
  - mode_q=0: phase_o = all ones, phase_idx_o = 0.
  - Not in RUN: phase_o = 0.
- Mid-instruction reset: a press during RUN, at any phase, forces phase_o=0 in the cycle after btn_o[0] rises. The phase counter returns to 0; there is no partial-instruction completion.
- Simultaneous events: rst has priority over everything. A button press in the same cycle as HOLD expiry goes to ASSERT, not RUN.

Decomposition:
- Package clk_rst_pkg:
  - rst_state_e enum (ASSERT, HOLD, RUN).
  - Phase-bit constants PH_CORE=0, PH_IMEM=1, PH_DMEM=2.
  - MODE_SINGLE/MODE_MULTI constants.
- Sub-module btn_debounce: synchroniser, counter, level and edge outputs for one channel, parametrised by DEB_LEN and BTN_ACTIVE_LOW.
  - Instantiated NUM_BTN times via generate.
  - Reset FSM and phase generator stay in the top of clk_rst_ctrl.

Test Plan:
- Power-up: DEB_LEN=16, RST_HOLD=8, mode_i=1, pin released, rst high 5 cycles then low → core_rst_o falls exactly 8 cycles after rst deasserts. phase_o then reads 001,010,100,001… each cycle.
- Glitch rejection: low pulse of 10 cycles on btn_i[0] → btn_o stays 0, core_rst_o stays 0, no edge pulses. Low held 20 cycles → btn_o[0]=1 at t+18, btn_rise_o pulses once, phase_o=000 next cycle.
- Mid-instruction reset: press while phase_o=010, hold, release → core_rst_o=1 throughout. After the release is debounced plus 8 cycles, the first phase_o is 001.
- Mode freeze: mode_i=0 through reset → phase_o=111 every RUN cycle. Toggling mode_i to 1 during RUN → still 111. After the next button reset → rotation.
- Multi-channel: NUM_BTN=3, NUM_PHASES=4. Press btn 2 only → btn_o=100 after DEB_LEN+2 cycles and core_rst_o unaffected. Phase wraps 0001→1000→0001.
- Priority: btn_o[0] rises in the last HOLD cycle → FSM goes to ASSERT and core_rst_o never drops.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock-phase / reset controller.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RUN
    } rst_state_e;

    localparam int unsigned PH_CORE = 0;
    localparam int unsigned PH_IMEM = 1;
    localparam int unsigned PH_DMEM = 2;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_MULTI  = 1'b1;

endpackage

// File: rtl/clk_rst_ctrl_btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity fix, stability counter,
// debounced level and registered press/release pulses.
module btn_debounce
    import clk_rst_pkg::*;
#(
    parameter int unsigned DEB_LEN        = 16,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic btn_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(DEB_LEN);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed, differ, toggle;

    // A gap in the mismatch clears the count, so only an unbroken run toggles.
    always_comb begin
        pressed = sync2_q ^ BTN_ACTIVE_LOW;
        differ  = (pressed != level_q);
        toggle  = differ && (cnt_q == CW'(DEB_LEN - 1));
        cnt_d   = (!differ || toggle) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= BTN_ACTIVE_LOW;
            sync2_q <= BTN_ACTIVE_LOW;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            rise_q  <= toggle && !level_q;
            fall_q  <= toggle && level_q;
            if (toggle) begin
                level_q <= !level_q;
            end
        end
    end

    assign btn_o  = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// Button debouncing, core reset sequencing and one-hot phase strobes that let
// a multi-cycle core with synchronous BSRAM run from a single clock.
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int unsigned NUM_BTN        = 1,
    parameter int unsigned DEB_LEN        = 16,
    parameter int unsigned NUM_PHASES     = 3,
    parameter int unsigned RST_HOLD       = 8,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BTN-1:0]            btn_i,
    input  logic                          mode_i,
    output logic [NUM_BTN-1:0]            btn_o,
    output logic [NUM_BTN-1:0]            btn_rise_o,
    output logic [NUM_BTN-1:0]            btn_fall_o,
    output logic                          core_rst_o,
    output logic [NUM_PHASES-1:0]         phase_o,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx_o
);

    localparam int unsigned PW = $clog2(NUM_PHASES);
    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEB_LEN        (DEB_LEN),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_i[g]),
            .btn_o  (btn_o[g]),
            .rise_o (btn_rise_o[g]),
            .fall_o (btn_fall_o[g])
        );
    end

    rst_state_e            state_q;
    logic [HW-1:0]         hold_cnt_q;
    logic                  core_rst_q;
    logic                  mode_q, mode_d;
    logic [PW-1:0]         phase_cnt_q, phase_cnt_d;
    logic [NUM_PHASES-1:0] phase_q;
    logic [PW-1:0]         phase_idx_q;

    always_comb begin
        mode_d      = (state_q == RUN) ? mode_q : mode_i;
        phase_cnt_d = (phase_cnt_q == PW'(NUM_PHASES - 1)) ? '0 : phase_cnt_q + PW'(1);
    end

    // Strobes are registered: each branch loads the value for the coming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ASSERT;
            hold_cnt_q  <= '0;
            core_rst_q  <= 1'b1;
            mode_q      <= MODE_SINGLE;
            phase_cnt_q <= '0;
            phase_q     <= '0;
            phase_idx_q <= '0;
        end else begin
            mode_q <= mode_d;
            case (state_q)
                ASSERT: begin
                    core_rst_q  <= 1'b1;
                    hold_cnt_q  <= '0;
                    phase_cnt_q <= '0;
                    phase_q     <= '0;
                    phase_idx_q <= '0;
                    if (!btn_o[0]) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (btn_o[0]) begin
                        state_q    <= ASSERT;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
                        state_q     <= RUN;
                        core_rst_q  <= 1'b0;
                        phase_cnt_q <= '0;
                        phase_idx_q <= '0;
                        phase_q     <= (mode_d == MODE_MULTI) ? NUM_PHASES'(1) : '1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                RUN: begin
                    if (btn_o[0]) begin
                        state_q     <= ASSERT;
                        core_rst_q  <= 1'b1;
                        phase_cnt_q <= '0;
                        phase_q     <= '0;
                        phase_idx_q <= '0;
                    end else begin
                        phase_cnt_q <= phase_cnt_d;
                        if (mode_q == MODE_MULTI) begin
                            phase_q     <= NUM_PHASES'(1) << phase_cnt_d;
                            phase_idx_q <= phase_cnt_d;
                        end else begin
                            phase_q     <= '1;
                            phase_idx_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= ASSERT;
                    core_rst_q <= 1'b1;
                    phase_q    <= '0;
                end
            endcase
        end
    end

    assign core_rst_o  = core_rst_q;
    assign phase_o     = phase_q;
    assign phase_idx_o = phase_idx_q;

endmodule
